md_sequencer: RTL and testbench
===============================

Name: md_sequencer

Overview:
Sequencer for the shared multiply/divide unit and the HIGH/LOW register pair in the multicycle CPU.
- The main control FSM raises a request; this block takes over from there.
- It pulses the multi_div start (crtl_setmd) and counts the unit's fixed latency.
- It then commits the result to HIGH/LOW and returns a done pulse.
- It detects divide-by-zero before starting and raises a one-cycle exception pulse instead.

Parameters:
MD_CYCLES, 32, cycles multi_div needs after crtl_setmd before its HIGH/LOW outputs are valid; must be >= 1.
CNT_W, $clog2(MD_CYCLES+1), counter width; localparam, derived, not overridable.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (rst=0 resets)
md_req  in  1  request from control unit; level, held until md_done or md_div0 is seen
md_op  in  1  0=MULT, 1=DIV; sampled only on acceptance
md_divisor  in  32  REG_B output; checked on acceptance when md_op=1
md_flush  in  1  synchronous abort (exception/reset flow in control unit)
md_busy  out  1  high in every state except IDLE
md_done  out  1  one-cycle pulse: HIGH/LOW written
md_div0  out  1  one-cycle pulse: DIV with divisor 0, nothing started
crtl_setmd  out  1  one-cycle start pulse to multi_div
crtl_reghigh  out  1  HIGH register write enable
crtl_reglow  out  1  LOW register write enable

Behaviour:
- All outputs are Moore outputs, decoded from the state register only. There is no combinational path from inputs to outputs.
- Reset (rst=0, async): state=IDLE, counter=0, all outputs 0. This applies from any state, including mid-WAIT. A multi_div run in progress is abandoned and HIGH/LOW are not written.
- States: IDLE, START, WAIT, WRITE, DONE, EXC.
- IDLE: on md_req=1 and md_flush=0:
  - if md_op=1 and md_divisor==32'h0, go to EXC;
  - otherwise go to START.
  - md_req=0 stays in IDLE.
- START: crtl_setmd=1; counter<=MD_CYCLES-1; next state WAIT.
- WAIT: counter decrements each cycle; when counter==0, go to WRITE. WAIT lasts exactly MD_CYCLES cycles.
- WRITE: crtl_reghigh=crtl_reglow=1 (both, for MULT and DIV); next state DONE.
- DONE: md_done=1; next state IDLE.
- EXC: md_div0=1; next state IDLE. No crtl_setmd and no HIGH/LOW write occur.
- Latency, with acceptance cycle = 0:
  - crtl_setmd at cycle 1;
  - write enables at cycle MD_CYCLES+2;
  - md_done at cycle MD_CYCLES+3;
  - md_busy high in cycles 1..MD_CYCLES+3.
  - Divide-by-zero: md_div0 and md_busy high at cycle 1 only.
- Request handshake: the requester must drop md_req on the edge after it sees md_done or md_div0. md_req=1 in IDLE always means a new request. Minimum back-to-back spacing is therefore one IDLE cycle.
- md_op and md_divisor are don't-care outside the IDLE acceptance cycle. Changes while busy have no effect.
- md_flush=1 in any state: next state is IDLE and the counter is cleared.
  - Outputs in the flush cycle still reflect the current state. Flush during WRITE therefore still writes HIGH/LOW, and flush during DONE still pulses md_done.
  - Flush in IDLE blocks acceptance that cycle.
  - md_flush and md_req both high in IDLE: flush wins, no acceptance.
- MD_CYCLES=1: WAIT lasts one cycle; counter loads 0.
- Counter never wraps: it is only decremented in WAIT while nonzero.

Decomposition:
- Shared package md_pkg holds:
  - state encoding localparams (IDLE..EXC, 3 bits);
  - MD_OP_MULT=1'b0, MD_OP_DIV=1'b1;
  - MD_CYCLES_DEFAULT=32.
- No sub-module. The down-counter and FSM are small enough to live in one module.
- Integration: crtl_setmd, crtl_reghigh and crtl_reglow feed the existing multi_div and HIGH/LOW registers directly. The control unit stops driving those three signals.

Test Plan:
- Reset: assert rst=0 at WAIT cycle 10 -> immediately all outputs 0 and md_busy=0. After rst=1, a new MULT request gets crtl_setmd exactly 1 cycle after acceptance.
- MULT, MD_CYCLES=32: md_req=1, md_op=0 at cycle 0 -> crtl_setmd at cycle 1, crtl_reghigh/crtl_reglow at cycle 34, md_done at cycle 35, md_busy high for cycles 1..35, md_div0 never asserted.
- DIV by zero: md_op=1, md_divisor=0 -> md_div0 at cycle 1, md_busy only at cycle 1, and no crtl_setmd, write enable or md_done at any time.
- DIV valid then back-to-back: md_divisor=7 gives the same timing as MULT. md_req dropped at cycle 36 and re-raised at cycle 37 -> second crtl_setmd at cycle 38.
- Flush: md_flush=1 at cycle 10 of a MULT -> IDLE at cycle 11, no write enables, no md_done. md_req at cycle 12 is accepted normally. Flush together with md_req in IDLE -> not accepted.
- MD_CYCLES=1 build: acceptance at cycle 0 -> crtl_setmd at 1, WAIT at 2, write at 3, md_done at 4.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding,
// operation codes and the Moore output decode used by md_sequencer.
package md_pkg;

    localparam int MD_CYCLES_DEFAULT = 32;

    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_EXC   = 3'd5;

    typedef struct packed {
        logic busy;
        logic done;
        logic div0;
        logic setmd;
        logic reghigh;
        logic reglow;
    } md_out_t;

    // Output pattern belonging to a state; every output is a pure function of it.
    function automatic md_out_t md_decode(input logic [2:0] st);
        md_out_t o;
        o = '0;
        case (st)
            ST_IDLE:  o = '0;
            ST_START: begin o.busy = 1'b1; o.setmd = 1'b1; end
            ST_WAIT:  o.busy = 1'b1;
            ST_WRITE: begin o.busy = 1'b1; o.reghigh = 1'b1; o.reglow = 1'b1; end
            ST_DONE:  begin o.busy = 1'b1; o.done = 1'b1; end
            ST_EXC:   begin o.busy = 1'b1; o.div0 = 1'b1; end
            default:  o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// Request/result handshake between the control unit and md_sequencer, plus
// the multi_div start and HIGH/LOW write strobes driven by the sequencer.
interface md_sequencer_if;
    logic        md_req;
    logic        md_op;
    logic [31:0] md_divisor;
    logic        md_flush;
    logic        md_busy;
    logic        md_done;
    logic        md_div0;
    logic        crtl_setmd;
    logic        crtl_reghigh;
    logic        crtl_reglow;

    modport master (
        output md_req, md_op, md_divisor, md_flush,
        input  md_busy, md_done, md_div0, crtl_setmd, crtl_reghigh, crtl_reglow
    );

    modport slave (
        input  md_req, md_op, md_divisor, md_flush,
        output md_busy, md_done, md_div0, crtl_setmd, crtl_reghigh, crtl_reglow
    );
endinterface

// File: rtl/md_sequencer.sv
// Sequences one multi_div operation: start pulse, fixed-latency wait,
// HIGH/LOW commit and done pulse, or a divide-by-zero exception pulse.
module md_sequencer
    import md_pkg::*;
#(
    parameter int MD_CYCLES = MD_CYCLES_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    md_sequencer_if.slave  bus
);

    localparam int                CNT_W    = $clog2(MD_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);

    logic [2:0]       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    md_out_t          out_d, out_q;

    // Next-state and latency counter; flush overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.md_flush) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.md_req) begin
                        if ((bus.md_op == MD_OP_DIV) && (bus.md_divisor == 32'h0)) begin
                            state_d = ST_EXC;
                        end else begin
                            state_d = ST_START;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_START: begin
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_q == CNT_ZERO) begin
                        state_d = ST_WRITE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_WRITE: state_d = ST_DONE;
                ST_DONE:  state_d = ST_IDLE;
                ST_EXC:   state_d = ST_IDLE;
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they line up
    // with the state register and never see an input combinationally.
    always_comb begin
        out_d = md_decode(state_d);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign bus.md_busy      = out_q.busy;
    assign bus.md_done      = out_q.done;
    assign bus.md_div0      = out_q.div0;
    assign bus.crtl_setmd   = out_q.setmd;
    assign bus.crtl_reghigh = out_q.reghigh;
    assign bus.crtl_reglow  = out_q.reglow;

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: a 32-cycle and a 1-cycle instance, checked every
// cycle against a timeline model derived from acceptance/flush cycle numbers.
module tb_md_sequencer;
    import md_pkg::*;

    localparam int MD_A = 32;
    localparam int MD_B = 1;
    localparam int NO_FLUSH = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    md_sequencer_if if_a ();
    md_sequencer_if if_b ();

    md_sequencer #(.MD_CYCLES(MD_A)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    md_sequencer #(.MD_CYCLES(MD_B)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    logic        req_v   [2];
    logic        op_v    [2];
    logic        flush_v [2];
    logic [31:0] div_v   [2];

    assign if_a.md_req = req_v[0];  assign if_a.md_op = op_v[0];
    assign if_a.md_divisor = div_v[0];  assign if_a.md_flush = flush_v[0];
    assign if_b.md_req = req_v[1];  assign if_b.md_op = op_v[1];
    assign if_b.md_divisor = div_v[1];  assign if_b.md_flush = flush_v[1];

    // observed bits: busy, done, div0, setmd, reghigh, reglow
    logic [5:0] obs_v [2];
    assign obs_v[0] = {if_a.md_busy, if_a.md_done, if_a.md_div0,
                       if_a.crtl_setmd, if_a.crtl_reghigh, if_a.crtl_reglow};
    assign obs_v[1] = {if_b.md_busy, if_b.md_done, if_b.md_div0,
                       if_b.crtl_setmd, if_b.crtl_reghigh, if_b.crtl_reglow};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mdv  [2];
    bit act  [2];
    int acc  [2];
    bit dz   [2];
    int fend [2];
    logic [5:0] exp_v [2];

    function automatic string out_name(input int i);
        case (i)
            5: return "md_busy";
            4: return "md_done";
            3: return "md_div0";
            2: return "crtl_setmd";
            1: return "crtl_reghigh";
            default: return "crtl_reglow";
        endcase
    endfunction

    // Last busy cycle (relative to acceptance) of the current transaction.
    function automatic int end_k(input int d);
        int lastk;
        lastk = dz[d] ? 1 : mdv[d] + 3;
        return (fend[d] < lastk) ? fend[d] : lastk;
    endfunction

    task automatic compute_exp();
        for (int d = 0; d < 2; d++) begin
            int k;
            bit on;
            k  = cyc - acc[d];
            on = act[d] && (k >= 1) && (k <= end_k(d));
            exp_v[d][5] = on;
            exp_v[d][4] = on && !dz[d] && (k == mdv[d] + 3);
            exp_v[d][3] = on &&  dz[d] && (k == 1);
            exp_v[d][2] = on && !dz[d] && (k == 1);
            exp_v[d][1] = on && !dz[d] && (k == mdv[d] + 2);
            exp_v[d][0] = on && !dz[d] && (k == mdv[d] + 2);
        end
    endtask

    task automatic chk(input string tag, input int d, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s dut%0d cyc=%0d observed=%0b expected=%0b", tag, d, cyc, obs, expv);
        end
    endtask

    task automatic check_all();
        compute_exp();
        for (int d = 0; d < 2; d++)
            for (int i = 5; i >= 0; i--)
                chk(out_name(i), d, obs_v[d][i], exp_v[d][i]);
    endtask

    // Model update for the inputs present at the coming edge.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                act[d] = 1'b0;
            end else begin
                if (act[d] && (cyc - acc[d]) > end_k(d)) act[d] = 1'b0;
                if (!act[d]) begin
                    if (req_v[d] && !flush_v[d]) begin
                        act[d]  = 1'b1;
                        acc[d]  = cyc;
                        dz[d]   = (op_v[d] == MD_OP_DIV) && (div_v[d] == 32'h0);
                        fend[d] = NO_FLUSH;
                    end
                end else if (flush_v[d] && (cyc - acc[d]) < fend[d]) begin
                    fend[d] = cyc - acc[d];
                end
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    // One request on instance d; optional flush or reset at relative cycle k.
    task automatic run_txn(input int d, input logic op, input logic [31:0] dv,
                           input int flush_k, input int rst_k);
        bit fin;
        int k;
        fin = 1'b0;
        req_v[d] = 1'b1; op_v[d] = op; div_v[d] = dv;
        step();
        for (int n = 0; n < 80 && !fin; n++) begin
            k = cyc - acc[d];
            if (flush_k > 0 && k == flush_k) begin
                flush_v[d] = 1'b1; req_v[d] = 1'b0;
                step();
                flush_v[d] = 1'b0;
                fin = 1'b1;
            end else if (rst_k > 0 && k == rst_k) begin
                #2;
                rst = 1'b0;
                req_v[d] = 1'b0;
                #1;
                act[0] = 1'b0; act[1] = 1'b0;
                check_all();
                step();
                step();
                rst = 1'b1;
                fin = 1'b1;
            end else if (exp_v[d][4] || exp_v[d][3]) begin
                step();
                req_v[d] = 1'b0;
                fin = 1'b1;
            end else begin
                op_v[d]  = 1'($urandom);
                div_v[d] = 32'($urandom);
                step();
            end
        end
        total++;
        assert (fin === 1'b1) else begin
            bad++;
            $error("FAIL timeout dut%0d cyc=%0d observed=%0b expected=%0b", d, cyc, fin, 1'b1);
        end
    endtask

    initial begin
        mdv[0] = MD_A; mdv[1] = MD_B;
        for (int d = 0; d < 2; d++) begin
            req_v[d] = 1'b0; op_v[d] = 1'b0; flush_v[d] = 1'b0; div_v[d] = 32'h0;
            act[d] = 1'b0; acc[d] = 0; dz[d] = 1'b0; fend[d] = NO_FLUSH;
        end
        rst = 1'b0;
        #1;
        check_all();
        step();
        step();
        rst = 1'b1;
        step();

        // 32-cycle instance: directed cases
        run_txn(0, MD_OP_MULT, 32'($urandom), 0, 0);  step();
        run_txn(0, MD_OP_DIV, 32'h0, 0, 0);           step();
        run_txn(0, MD_OP_DIV, 32'd7, 0, 0);           step();
        run_txn(0, MD_OP_MULT, 32'h0, 0, 0);          step();
        run_txn(0, MD_OP_MULT, 32'h5, 10, 0);         step();
        run_txn(0, MD_OP_DIV, 32'h3, 0, 0);           step();
        req_v[0] = 1'b1; flush_v[0] = 1'b1;
        step();
        req_v[0] = 1'b0; flush_v[0] = 1'b0;
        step();
        run_txn(0, MD_OP_MULT, 32'h1, 0, 12);         step();
        run_txn(0, MD_OP_MULT, 32'h1, 0, 0);          step();
        run_txn(0, MD_OP_MULT, 32'h9, 34, 0);         step();
        run_txn(0, MD_OP_DIV, 32'h9, 35, 0);          step();

        // 1-cycle instance: directed cases including flush in WAIT/WRITE/DONE
        run_txn(1, MD_OP_MULT, 32'h2, 0, 0);          step();
        run_txn(1, MD_OP_DIV, 32'h0, 0, 0);           step();
        run_txn(1, MD_OP_DIV, 32'h4, 0, 0);
        run_txn(1, MD_OP_MULT, 32'h4, 0, 0);          step();
        for (int f = 1; f <= 4; f++) begin
            run_txn(1, MD_OP_MULT, 32'h6, f, 0);
            step();
        end

        // randomized transactions on both instances
        for (int t = 0; t < 24; t++) begin
            int d;
            int fk;
            logic op;
            logic [31:0] dv;
            d  = int'($urandom_range(1, 0));
            op = 1'($urandom);
            dv = ($urandom_range(2, 0) == 0) ? 32'h0 : 32'($urandom);
            fk = 0;
            if ($urandom_range(3, 0) == 0) fk = int'($urandom_range(mdv[d] + 3, 1));
            run_txn(d, op, dv, fk, 0);
            repeat ($urandom_range(2, 0)) step();
        end
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
